// File: rtl/assert_report_arbiter.sv
// assert_report_arbiter
// Gathers single-cycle failure pulses from N_SRC assertion monitors.
// Keeps sticky, saturating-count and overflow status for each source.
// Pending events share one valid/ready report channel, served round-robin.
// Each report carries the free-running cycle stamp of the failure it reports.
module assert_report_arbiter #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         fail,
    input  logic                     clear,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [$clog2(N_SRC)-1:0] rpt_id,
    output logic [TS_W-1:0]          rpt_ts,
    output logic                     any_fail,
    output logic [N_SRC-1:0]         fail_sticky,
    output logic [N_SRC-1:0]         overflow,
    output logic [N_SRC*CNT_W-1:0]   fail_count
);

    localparam int ID_W = $clog2(N_SRC);

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } state_e;

    // Free-running timestamp
    logic [TS_W-1:0]  ts_q;

    // Per-source status
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] sticky_q,  sticky_d;
    logic [N_SRC-1:0] ovf_q,     ovf_d;
    logic [CNT_W-1:0] cnt_q     [N_SRC];
    logic [CNT_W-1:0] cnt_d     [N_SRC];
    logic [TS_W-1:0]  pend_ts_q [N_SRC];
    logic [TS_W-1:0]  pend_ts_d [N_SRC];

    // Report channel
    state_e           state_q;
    logic             rpt_valid_q;
    logic [ID_W-1:0]  rpt_id_q;
    logic [TS_W-1:0]  rpt_ts_q;
    logic [ID_W-1:0]  rr_ptr_q;

    logic             accept;
    logic [N_SRC-1:0] accept_oh;
    logic             sel_found;
    logic [ID_W-1:0]  sel_idx;

    assign accept = rpt_valid_q && rpt_ready;

    // Timestamp counter: wraps naturally and ignores clear
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // One-hot of the source whose report is being accepted this cycle
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            accept_oh[i] = accept && (rpt_id_q == ID_W'(i));
        end
    end

    // Round-robin pick: first pending index at or after rr_ptr, wrapping
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!sel_found && pending_q[(int'(rr_ptr_q) + k) % N_SRC]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'((int'(rr_ptr_q) + k) % N_SRC);
            end
        end
    end

    // Next-state of per-source status; clear wins over a same-cycle failure
    always_comb begin
        pending_d = pending_q;
        sticky_d  = sticky_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i]     = cnt_q[i];
            pend_ts_d[i] = pend_ts_q[i];
        end
        if (clear) begin
            pending_d = '0;
            sticky_d  = '0;
            ovf_d     = '0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_d[i]     = '0;
                pend_ts_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (fail[i]) begin
                    sticky_d[i] = 1'b1;
                    if (cnt_q[i] != {CNT_W{1'b1}}) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    // A free slot, or one being drained right now, takes the new event;
                    // otherwise the oldest unreported event is kept and overflow flags the loss.
                    if (!pending_q[i] || accept_oh[i]) begin
                        pending_d[i] = 1'b1;
                        pend_ts_d[i] = ts_q;
                    end else begin
                        ovf_d[i] = 1'b1;
                    end
                end else if (accept_oh[i]) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
    end

    // Per-source status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            sticky_q  <= '0;
            ovf_q     <= '0;
            // NOTE: these small per-source arrays are flops, not RAM, so resetting them is cheap and keeps outputs defined.
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i]     <= '0;
                pend_ts_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i]     <= cnt_d[i];
                pend_ts_q[i] <= pend_ts_d[i];
            end
        end
    end

    // Report FSM with registered channel outputs and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rpt_valid_q <= 1'b0;
            rpt_id_q    <= '0;
            rpt_ts_q    <= '0;
            rr_ptr_q    <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            rpt_valid_q <= 1'b0;
            rpt_id_q    <= '0;
            rpt_ts_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sel_found) begin
                        rpt_id_q    <= sel_idx;
                        rpt_ts_q    <= pend_ts_q[sel_idx];
                        rpt_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        rr_ptr_q    <= (rpt_id_q == ID_W'(N_SRC - 1)) ? '0 : rpt_id_q + ID_W'(1);
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Output packing
    always_comb begin
        fail_count = '0;
        for (int i = 0; i < N_SRC; i++) begin
            fail_count[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign rpt_valid   = rpt_valid_q;
    assign rpt_id      = rpt_id_q;
    assign rpt_ts      = rpt_ts_q;
    assign fail_sticky = sticky_q;
    assign overflow    = ovf_q;
    assign any_fail    = |sticky_q;

endmodule

// File: tb/tb_assert_report_arbiter.sv
// Testbench for assert_report_arbiter (N_SRC=4, CNT_W=8, TS_W=16).
// Table-driven cycle vectors for the basic and multi-source report flows,
// then hand-written sequences for overflow, saturation, clear and reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_assert_report_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  fail;
    logic        clear;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [1:0]  rpt_id;
    logic [15:0] rpt_ts;
    logic        any_fail;
    logic [3:0]  fail_sticky;
    logic [3:0]  overflow;
    logic [31:0] fail_count;

    int n_checks = 0;
    int n_errors = 0;

    assert_report_arbiter #(
        .N_SRC (4),
        .CNT_W (8),
        .TS_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fail        (fail),
        .clear       (clear),
        .rpt_valid   (rpt_valid),
        .rpt_ready   (rpt_ready),
        .rpt_id      (rpt_id),
        .rpt_ts      (rpt_ts),
        .any_fail    (any_fail),
        .fail_sticky (fail_sticky),
        .overflow    (overflow),
        .fail_count  (fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One vector = one clock cycle: inputs for that cycle and expected outputs seen during it
    typedef struct {
        logic [3:0]  fail;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_id;
        logic [15:0] exp_ts;
        logic [3:0]  exp_sticky;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] f, input logic r, input logic v,
                                input logic [1:0] id, input logic [15:0] ts, input logic [3:0] st);
        vec_t e;
        e.fail       = f;
        e.ready      = r;
        e.exp_valid  = v;
        e.exp_id     = id;
        e.exp_ts     = ts;
        e.exp_sticky = st;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then move to the next falling edge
    task automatic step(input logic [3:0] f, input logic r, input logic c);
        fail      = f;
        rpt_ready = r;
        clear     = c;
        @(negedge clk);
    endtask

    // Pulse reset; returns on the falling edge whose cycle has timestamp 0
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        fail      = '0;
        rpt_ready = 1'b0;
        clear     = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) begin
            check($sformatf("%s[%0d].valid", tag, i - lo), rpt_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("%s[%0d].id", tag, i - lo), rpt_id, vecs[i].exp_id);
                check($sformatf("%s[%0d].ts", tag, i - lo), rpt_ts, vecs[i].exp_ts);
            end
            check($sformatf("%s[%0d].sticky", tag, i - lo), fail_sticky, vecs[i].exp_sticky);
            step(vecs[i].fail, vecs[i].ready, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_lo, a_hi, b_lo, b_hi, nrep;

        reset     = 1'b0;
        fail      = '0;
        clear     = 1'b0;
        rpt_ready = 1'b0;

        // Table A: single failure on source 1 at ts=5, ready held high
        a_lo = vecs.size();
        for (int t = 0; t < 5; t++) add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0000);
        add(4'b0010, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0000);   // ts 5
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0010);   // ts 6
        add(4'b0000, 1'b1, 1'b1, 2'd1, 16'd5, 4'b0010);   // ts 7: report
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0010);   // ts 8
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0010);   // ts 9
        a_hi = vecs.size();

        // Table B: simultaneous failures 0,1,3 at ts=10, then source 0 again at ts=19
        b_lo = vecs.size();
        for (int t = 0; t < 10; t++) add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0, 4'b0000);
        add(4'b1011, 1'b1, 1'b0, 2'd0, 16'd0,  4'b0000);  // ts 10
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 11
        add(4'b0000, 1'b1, 1'b1, 2'd0, 16'd10, 4'b1011);  // ts 12
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 13
        add(4'b0000, 1'b1, 1'b1, 2'd1, 16'd10, 4'b1011);  // ts 14
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 15
        add(4'b0000, 1'b1, 1'b1, 2'd3, 16'd10, 4'b1011);  // ts 16
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 17
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 18
        add(4'b0001, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 19
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 20
        add(4'b0000, 1'b1, 1'b1, 2'd0, 16'd19, 4'b1011);  // ts 21: pointer wrapped from 3
        add(4'b0000, 1'b1, 1'b0, 2'd0, 16'd0,  4'b1011);  // ts 22
        b_hi = vecs.size();

        // Idle after reset
        do_reset();
        for (int t = 0; t < 20; t++) begin
            check("idle.valid", rpt_valid, 1'b0);
            check("idle.any_fail", any_fail, 1'b0);
            check("idle.count", fail_count, 32'h0);
            step(4'b0000, 1'b0, 1'b0);
        end

        do_reset();
        run_vecs(a_lo, a_hi, "single");
        check("single.count", fail_count, 32'h0000_0100);
        check("single.overflow", overflow, 4'b0000);
        check("single.any_fail", any_fail, 1'b1);

        do_reset();
        run_vecs(b_lo, b_hi, "multi");
        check("multi.count", fail_count, 32'h0100_0102);
        check("multi.overflow", overflow, 4'b0000);

        // Held report with repeated failures on source 2 while ready is low
        do_reset();
        for (int t = 0; t < 15; t++) begin
            if (t == 5) begin
                check("hold5.valid", rpt_valid, 1'b1);
                check("hold5.id", rpt_id, 2'd2);
                check("hold5.ts", rpt_ts, 16'd3);
            end
            if (t == 13) begin
                check("hold13.valid", rpt_valid, 1'b1);
                check("hold13.id", rpt_id, 2'd2);
                check("hold13.ts", rpt_ts, 16'd3);
                check("hold13.overflow", overflow, 4'b0100);
                check("hold13.count2", fail_count[23:16], 8'd3);
            end
            step((t == 3 || t == 8 || t == 12) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
        end
        nrep = 0;
        for (int t = 15; t < 27; t++) begin
            if (rpt_valid) nrep++;
            step(4'b0000, 1'b1, 1'b0);
        end
        check("hold.reports", nrep, 1);
        check("hold.overflow_kept", overflow, 4'b0100);

        // Failure on source 1 in the same cycle its report is accepted
        do_reset();
        for (int t = 0; t < 10; t++) begin
            if (t == 4) begin
                check("reacc4.valid", rpt_valid, 1'b1);
                check("reacc4.ts", rpt_ts, 16'd2);
            end
            if (t == 6) check("reacc6.ts", rpt_ts, 16'd2);
            if (t == 7) check("reacc7.valid", rpt_valid, 1'b0);
            if (t == 8) begin
                check("reacc8.valid", rpt_valid, 1'b1);
                check("reacc8.id", rpt_id, 2'd1);
                check("reacc8.ts", rpt_ts, 16'd6);
            end
            step((t == 2 || t == 6) ? 4'b0010 : 4'b0000, (t >= 6) ? 1'b1 : 1'b0, 1'b0);
        end
        check("reacc.valid_end", rpt_valid, 1'b0);
        check("reacc.overflow", overflow, 4'b0000);
        check("reacc.count1", fail_count[15:8], 8'd2);

        // Counter saturation on source 0
        do_reset();
        repeat (255) step(4'b0001, 1'b1, 1'b0);
        check("sat.at255", fail_count[7:0], 8'd255);
        repeat (45) step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("sat.after300", fail_count, 32'h0000_00FF);
        check("sat.sticky", fail_sticky, 4'b0001);

        // Clear during PRESENT together with a failure on source 1
        do_reset();
        for (int t = 0; t < 4; t++) begin
            if (t == 3) begin
                check("clr.pre_valid", rpt_valid, 1'b1);
                check("clr.pre_ts", rpt_ts, 16'd1);
            end
            step((t == 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
        end
        check("clr.pre_valid4", rpt_valid, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        check("clr.valid", rpt_valid, 1'b0);
        check("clr.sticky", fail_sticky, 4'b0000);
        check("clr.overflow", overflow, 4'b0000);
        check("clr.count", fail_count, 32'h0);
        check("clr.any_fail", any_fail, 1'b0);
        nrep = 0;
        for (int t = 0; t < 8; t++) begin
            if (rpt_valid) nrep++;
            step(4'b0000, 1'b1, 1'b0);
        end
        check("clr.no_report", nrep, 0);

        // Asynchronous reset while a report is presented
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        check("arst.pre_valid", rpt_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst.valid", rpt_valid, 1'b0);
        check("arst.count", fail_count, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/assert_report_arbiter.md
Name: assert_report_arbiter

Overview:
Collects single-cycle failure pulses from up to N hardware assertion monitors, such as the toggle-circuit checker. It keeps per-source sticky, counting and overflow status, and shares one report channel between the sources. The channel uses valid/ready and round-robin arbitration. The block sits between the assertion monitors and the debug/log interface, stamping each report with a free-running cycle count.

Parameters:
N_SRC, 4, number of assertion sources (2..16)
CNT_W, 8, width of per-source saturating failure counter
TS_W, 16, width of free-running timestamp counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset
fail  input  N_SRC  per-source failure pulse, bit i high = monitor i failed this cycle
clear  input  1  synchronous clear of all status, pending reports and FSM
rpt_valid  output  1  report present on rpt_id/rpt_ts
rpt_ready  input  1  consumer accepts report when rpt_valid && rpt_ready
rpt_id  output  $clog2(N_SRC)  source index of current report
rpt_ts  output  TS_W  timestamp of the failure being reported
any_fail  output  1  OR of fail_sticky
fail_sticky  output  N_SRC  bit i set on any failure of source i since reset/clear
overflow  output  N_SRC  bit i set when a failure of i arrived while a report for i was still pending
fail_count  output  N_SRC*CNT_W  packed saturating counters, source i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (reset=0, async): all outputs 0; timestamp 0; pending 0; RR pointer 0; FSM IDLE.
- Timestamp: ts increments by 1 every cycle, wraps 2^TS_W-1 -> 0, and is unaffected by clear.
- Per-source status, on cycle with fail[i]=1 and clear=0:
  - fail_sticky[i] <= 1.
  - fail_count[i] <= fail_count[i]+1, saturating at 2^CNT_W-1 with no wrap.
  - If pending[i]=0: pending[i] <= 1, pend_ts[i] <= ts.
  - If pending[i]=1 and not being accepted this cycle: overflow[i] <= 1, pend_ts[i] unchanged (the first failure is kept).
  - If pending[i]=1 and the report for i is accepted this cycle: pending[i] stays 1 and pend_ts[i] <= ts (a new event). No overflow.
- FSM states IDLE and PRESENT:
  - IDLE: if any pending, select the first pending index at or after rr_ptr, searching upward and wrapping modulo N_SRC.
  - IDLE, on selection: load rpt_id and rpt_ts <= pend_ts[id], go to PRESENT. rpt_valid=1 from the next cycle.
  - IDLE, nothing pending: stay in IDLE with rpt_valid=0.
  - PRESENT: rpt_valid=1; rpt_id and rpt_ts held stable until accepted.
  - PRESENT, on accept: clear pending[rpt_id] (subject to the rule above), rr_ptr <= (rpt_id+1) mod N_SRC, go to IDLE.
  - Throughput is at most one report per 2 cycles.
- Latency: fail[i] pulsed at cycle t with nothing pending gives rpt_valid=1 at cycle t+2.
- Simultaneous fails on several sources: all are recorded the same cycle and reported in RR order, each keeping its own timestamp.
- clear=1:
  - Next cycle: sticky, overflow, counts and pending are 0; FSM in IDLE; rpt_valid=0.
  - clear has priority over fail in the same cycle, so that failure is dropped.
  - clear during PRESENT abandons the report. This is the only permitted rpt_valid drop without a handshake.
- Reset mid-report: rpt_valid drops immediately (async).
- rpt_ready while rpt_valid=0 is ignored.

Test Plan:
- Reset release, no fail, 20 cycles -> rpt_valid=0, any_fail=0, all counts 0.
- fail=4'b0010 at ts=5, rpt_ready=1 -> rpt_valid at ts=7 with rpt_id=1 and rpt_ts=5. Accepted in that cycle. fail_count[1]=1, fail_sticky=4'b0010.
- fail=4'b1011 at ts=10, rpt_ready=1 -> reports ids 0,1,3 in order, all with rpt_ts=10, 2 cycles apart. Then a pulse fail=4'b0001 -> next report id=0 (RR pointer wrapped from 3).
- rpt_ready=0, fail[2] pulsed at ts=3, 8, 12 -> rpt_id=2 and rpt_ts=3 held stable. overflow=4'b0100, fail_count[2]=3. After ready, exactly one report for id 2.
- CNT_W=8, 300 pulses on fail[0] -> fail_count[0]=255, no wrap.
- clear asserted during PRESENT together with fail[1] -> next cycle rpt_valid=0, all status 0, no report for source 1. Async reset during PRESENT -> rpt_valid=0 immediately.
